ibra_axi4_mem_responder: RTL and testbench

// AXI4 slave memory model that answers the m_axi_* initiator port of the ibra NoC-to-AXI4 bridge.

---
 rtl/ibra_axi4_mem_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ibra_axi4_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibra_axi4_mem_responder.sv
// AXI4 slave memory model for the far end of the ibra NoC-to-AXI4 bridge initiator port.
// Serves one AR or AW burst at a time from a DATA_WIDTH-wide word array.
module ibra_axi4_mem_responder #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 11,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t                  state_r;
  logic                    last_rd_r;
  logic [ID_WIDTH-1:0]     id_r;
  logic [7:0]              len_r;
  logic [1:0]              burst_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    dec_err_r;
  logic [8:0]              wcnt_r;
  logic [7:0]              rbeat_r;

  logic                    awready_r;
  logic                    arready_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic [ID_WIDTH-1:0]     bid_r;
  logic [1:0]              bresp_r;
  logic                    rvalid_r;
  logic [ID_WIDTH-1:0]     rid_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [1:0]              rresp_r;
  logic                    rlast_r;

  logic [DATA_WIDTH-1:0]   mem_r [MEM_WORDS];

  logic [IDX_W-1:0]        aw_idx_s;
  logic [IDX_W-1:0]        ar_idx_s;
  logic                    aw_dec_s;
  logic                    ar_dec_s;
  logic [IDX_W-1:0]        idx_next_s;
  logic                    w_hs_s;
  logic                    r_hs_s;
  logic                    mem_we_s;
  logic [8:0]              wcnt_inc_s;
  logic [8:0]              exp_beats_s;
  logic [DATA_WIDTH-1:0]   rd_first_s;
  logic [DATA_WIDTH-1:0]   rd_next_s;
  logic                    unused_s;

  assign aw_idx_s    = s_axi_awaddr[OFF +: IDX_W];
  assign ar_idx_s    = s_axi_araddr[OFF +: IDX_W];
  assign aw_dec_s    = |s_axi_awaddr[ADDR_WIDTH-1:OFF+IDX_W];
  assign ar_dec_s    = |s_axi_araddr[ADDR_WIDTH-1:OFF+IDX_W];
  // WRAP is served like INCR; only FIXED keeps re-using the same word
  assign idx_next_s  = (burst_r == BURST_FIXED) ? idx_r : idx_r + IDX_ONE;
  assign w_hs_s      = (state_r == WR_DATA) && wready_r && s_axi_wvalid;
  assign r_hs_s      = rvalid_r && s_axi_rready;
  assign mem_we_s    = w_hs_s && !dec_err_r && !reset;
  assign wcnt_inc_s  = (wcnt_r == 9'h1FF) ? wcnt_r : wcnt_r + 9'd1;
  assign exp_beats_s = {1'b0, len_r} + 9'd1;
  assign rd_first_s  = ar_dec_s ? {DATA_WIDTH{1'b0}} : mem_r[ar_idx_s];
  assign rd_next_s   = dec_err_r ? {DATA_WIDTH{1'b0}} : mem_r[idx_next_s];

  assign unused_s = ^{s_axi_awaddr[OFF-1:0], s_axi_awsize, s_axi_awlock, s_axi_awcache,
                      s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser, s_axi_wuser,
                      s_axi_araddr[OFF-1:0], s_axi_arsize, s_axi_arlock, s_axi_arcache,
                      s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser};

  // Byte-masked array write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_r[idx_r][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with round-robin AW/AR arbitration and registered channel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      last_rd_r <= 1'b1;
      id_r      <= '0;
      len_r     <= 8'd0;
      burst_r   <= 2'b00;
      idx_r     <= '0;
      dec_err_r <= 1'b0;
      wcnt_r    <= 9'd0;
      rbeat_r   <= 8'd0;
      awready_r <= 1'b0;
      arready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
      rid_r     <= '0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // a ready pulse is the handshake cycle, since valid was already high when it was raised
          if (awready_r) begin
            awready_r <= 1'b0;
            if (s_axi_awvalid) begin
              id_r      <= s_axi_awid;
              len_r     <= s_axi_awlen;
              burst_r   <= s_axi_awburst;
              idx_r     <= aw_idx_s;
              dec_err_r <= aw_dec_s;
              wcnt_r    <= 9'd0;
              wready_r  <= 1'b1;
              state_r   <= WR_DATA;
            end
          end else if (arready_r) begin
            arready_r <= 1'b0;
            if (s_axi_arvalid) begin
              id_r      <= s_axi_arid;
              len_r     <= s_axi_arlen;
              burst_r   <= s_axi_arburst;
              idx_r     <= ar_idx_s;
              dec_err_r <= ar_dec_s;
              rbeat_r   <= 8'd0;
              rvalid_r  <= 1'b1;
              rid_r     <= s_axi_arid;
              rdata_r   <= rd_first_s;
              rresp_r   <= ar_dec_s ? RESP_DECERR : RESP_OKAY;
              rlast_r   <= (s_axi_arlen == 8'd0);
              state_r   <= RD_DATA;
            end
          end else if (s_axi_awvalid && (!s_axi_arvalid || last_rd_r)) begin
            awready_r <= 1'b1;
            last_rd_r <= 1'b0;
          end else if (s_axi_arvalid) begin
            arready_r <= 1'b1;
            last_rd_r <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_hs_s) begin
            wcnt_r <= wcnt_inc_s;
            idx_r  <= idx_next_s;
            if (s_axi_wlast) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              bid_r    <= id_r;
              if (wcnt_inc_s != exp_beats_s) begin
                bresp_r <= RESP_SLVERR;
              end else if (dec_err_r) begin
                bresp_r <= RESP_DECERR;
              end else begin
                bresp_r <= RESP_OKAY;
              end
              state_r <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_r <= 1'b0;
            bid_r    <= '0;
            bresp_r  <= RESP_OKAY;
            state_r  <= IDLE;
          end
        end
        RD_DATA: begin
          if (r_hs_s) begin
            if (rlast_r) begin
              rvalid_r <= 1'b0;
              rlast_r  <= 1'b0;
              rid_r    <= '0;
              rdata_r  <= '0;
              rresp_r  <= RESP_OKAY;
              state_r  <= IDLE;
            end else begin
              rbeat_r <= rbeat_r + 8'd1;
              idx_r   <= idx_next_s;
              rdata_r <= rd_next_s;
              rlast_r <= ((rbeat_r + 8'd1) == len_r);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_arready = arready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_buser   = {USER_WIDTH{1'b0}};
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_ruser   = {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_ibra_axi4_mem_responder.sv
// Directed self-checking bench for ibra_axi4_mem_responder (default parameters).
module tb_ibra_axi4_mem_responder;
  localparam int IDW = 6;
  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int UW  = 11;
  localparam int SW  = DW / 8;

  logic clk, reset;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, awready, arvalid, arready;
  logic [DW-1:0]  wdata, rdata;
  logic [SW-1:0]  wstrb;
  logic           wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic [UW-1:0]  buser, ruser;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  rd_data [16];
  logic           rd_last [16];
  logic [1:0]     rd_resp [16];
  logic [IDW-1:0] rd_id   [16];
  logic           rv_first;

  ibra_axi4_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd6),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awuser(11'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(11'd0),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd6),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_aruser(11'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int s);
    logic [DW-1:0] p;
    logic [31:0]   w;
    w = 32'h9E3779B1 * 32'(s) + 32'h0BADF00D;
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = w + 32'(i);
    return p;
  endfunction

  // seed -1 sends all-ones data, seed -2 all-zeros, otherwise pat(seed+beat)
  task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [SW-1:0] strb,
                           input int seed, output logic [1:0] resp, output logic [IDW-1:0] rsp_id);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin cyc(); n++; end
    chk("aw_ready_seen", awready, 1'b1);
    cyc();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata  = (seed == -1) ? {DW{1'b1}} : (seed == -2) ? {DW{1'b0}} : pat(seed + b);
      wstrb  = strb;
      wlast  = (b == nbeats - 1);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin cyc(); n++; end
      if (!wready) chk("w_ready_timeout", wready, 1'b1);
      cyc();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    chk("b_valid_seen", bvalid, 1'b1);
    resp = bresp; rsp_id = bid;
    cyc();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle, output int nb);
    int n;
    bit done, stall_chk;
    logic [DW-1:0] held;
    logic held_last;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin cyc(); n++; end
    chk("ar_ready_seen", arready, 1'b1);
    cyc();
    arvalid = 1'b0;
    rv_first = rvalid;
    nb = 0; done = 1'b0; stall_chk = 1'b0; held = '0; held_last = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      rready = toggle ? (i % 2 == 0) : 1'b1;
      if (rvalid) begin
        if (stall_chk) begin
          chk("stall_rdata_hold", rdata, held);
          chk("stall_rlast_hold", rlast, held_last);
        end
        if (rready) begin
          if (nb < 16) begin
            rd_data[nb] = rdata; rd_last[nb] = rlast; rd_resp[nb] = rresp; rd_id[nb] = rid;
          end
          nb++;
          done = rlast;
          stall_chk = 1'b0;
        end else begin
          held = rdata; held_last = rlast; stall_chk = 1'b1;
        end
      end
      cyc();
    end
    rready = 1'b0;
    if (!done) chk("r_last_timeout", done, 1'b1);
  endtask

  logic [1:0]     resp;
  logic [IDW-1:0] rsp_id;
  int             nb, ng, n;
  logic           both, grant_w [4];
  logic [DW-1:0]  exp_word;

  initial begin
    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) cyc();
    chk("reset_ctrl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'd0);
    chk("reset_ids", {bid, bresp, rid, rresp}, 16'd0);
    chk("reset_rdata", rdata, {DW{1'b0}});
    chk("reset_user", {buser, ruser}, 22'd0);
    reset = 1'b0;
    cyc();

    // single beat write then readback
    axi_write(6'd5, 64'h40, 8'd0, 2'b01, 1, {SW{1'b1}}, 1, resp, rsp_id);
    chk("single_bresp", resp, 2'b00);
    chk("single_bid", rsp_id, 6'd5);
    axi_read(6'd9, 64'h40, 8'd0, 2'b01, 1'b0, nb);
    chk("single_rvalid_next", rv_first, 1'b1);
    chk("single_nbeats", nb, 1);
    chk("single_rdata", rd_data[0], pat(1));
    chk("single_rlast", rd_last[0], 1'b1);
    chk("single_rresp", rd_resp[0], 2'b00);
    chk("single_rid", rd_id[0], 6'd9);

    // INCR len 3 starting at word MEM_WORDS-2 wraps the index
    axi_write(6'd3, 64'hFF80, 8'd3, 2'b01, 4, {SW{1'b1}}, 10, resp, rsp_id);
    chk("wrap_bresp", resp, 2'b00);
    axi_read(6'd3, 64'hFF80, 8'd3, 2'b01, 1'b0, nb);
    chk("wrap_nbeats", nb, 4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("wrap_rdata%0d", b), rd_data[b], pat(10 + b));
      chk($sformatf("wrap_rlast%0d", b), rd_last[b], b == 3);
    end
    axi_read(6'd1, 64'h0, 8'd0, 2'b01, 1'b0, nb);
    chk("wrap_word0", rd_data[0], pat(12));
    axi_read(6'd1, 64'h40, 8'd0, 2'b01, 1'b0, nb);
    chk("wrap_word1", rd_data[0], pat(13));

    // partial strobe over a zeroed word
    axi_write(6'd2, 64'h140, 8'd0, 2'b01, 1, {SW{1'b1}}, -2, resp, rsp_id);
    axi_write(6'd2, 64'h140, 8'd0, 2'b01, 1, 64'h1, -1, resp, rsp_id);
    axi_read(6'd2, 64'h140, 8'd0, 2'b01, 1'b0, nb);
    exp_word = '0;
    exp_word[7:0] = 8'hFF;
    chk("strobe_byte0", rd_data[0], exp_word);

    // both address channels valid: last grant was a read, so writes go first
    awid = 6'd7; awaddr = 64'h500; awlen = 8'd0; awburst = 2'b01;
    arid = 6'd8; araddr = 64'h540; arlen = 8'd0; arburst = 2'b01;
    wdata = pat(30); wstrb = {SW{1'b1}}; wlast = 1'b1; wvalid = 1'b1;
    bready = 1'b1; rready = 1'b1; awvalid = 1'b1; arvalid = 1'b1;
    ng = 0; both = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ng == 4) break;
      if (awready && arready) both = 1'b1;
      if (awready) begin grant_w[ng] = 1'b1; ng++; end
      else if (arready) begin grant_w[ng] = 1'b0; ng++; end
      cyc();
    end
    awvalid = 1'b0; arvalid = 1'b0;
    repeat (6) cyc();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
    chk("arb_count", ng, 4);
    chk("arb_exclusive", both, 1'b0);
    for (int g = 0; g < 4; g++) chk($sformatf("arb_grant%0d", g), grant_w[g], g % 2 == 0);

    // len 7 read with rready toggling
    axi_write(6'd4, 64'h1900, 8'd7, 2'b01, 8, {SW{1'b1}}, 40, resp, rsp_id);
    chk("burst8_bresp", resp, 2'b00);
    axi_read(6'd6, 64'h1900, 8'd7, 2'b01, 1'b1, nb);
    chk("burst8_nbeats", nb, 8);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("burst8_rdata%0d", b), rd_data[b], pat(40 + b));
      chk($sformatf("burst8_rlast%0d", b), rd_last[b], b == 7);
    end

    // early wlast and decode errors
    axi_write(6'd10, 64'h3200, 8'd3, 2'b01, 3, {SW{1'b1}}, 50, resp, rsp_id);
    chk("short_bresp", resp, 2'b10);
    axi_write(6'd11, 64'h10000, 8'd0, 2'b01, 1, {SW{1'b1}}, 60, resp, rsp_id);
    chk("decerr_bresp", resp, 2'b11);
    axi_read(6'd12, 64'h10000, 8'd1, 2'b01, 1'b0, nb);
    chk("decerr_nbeats", nb, 2);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("decerr_rdata%0d", b), rd_data[b], {DW{1'b0}});
      chk($sformatf("decerr_rresp%0d", b), rd_resp[b], 2'b11);
    end
    chk("decerr_rlast1", rd_last[1], 1'b1);
    axi_read(6'd1, 64'h0, 8'd0, 2'b01, 1'b0, nb);
    chk("decerr_no_write", rd_data[0], pat(12));

    // reset pulse in the middle of a stalled read
    arid = 6'd4; araddr = 64'h1900; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin cyc(); n++; end
    chk("rst_ar_seen", arready, 1'b1);
    cyc();
    arvalid = 1'b0;
    chk("rst_rvalid_before", rvalid, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rst_rvalid_after", rvalid, 1'b0);
    chk("rst_outputs_after", {rlast, rid, rresp, arready, awready}, 11'd0);
    reset = 1'b0;
    cyc();
    axi_read(6'd13, 64'h1900, 8'd0, 2'b01, 1'b0, nb);
    chk("post_rst_rvalid_next", rv_first, 1'b1);
    chk("post_rst_rdata", rd_data[0], pat(40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
